// File: rtl/nibble_serial_alu_seq_if.sv
// nibble_serial_alu_seq_if: request/result bus plus the 4-bit ALU drive/return lines.
interface nibble_serial_alu_seq_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;
  logic start;
  logic [2:0] op;
  logic cin_init;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic busy;
  logic done;
  logic [W-1:0] result;
  logic carry;
  logic zero;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_signal;
  logic alu_cin;
  logic [3:0] alu_out;
  logic alu_cout;
  modport master(
    output start, op, cin_init, a, b, alu_out, alu_cout,
    input busy, done, result, carry, zero, alu_a, alu_b, alu_signal, alu_cin
  );
  modport slave(
    input start, op, cin_init, a, b, alu_out, alu_cout,
    output busy, done, result, carry, zero, alu_a, alu_b, alu_signal, alu_cin
  );
endinterface

// File: rtl/nibble_serial_alu_seq.sv
// nibble_serial_alu_seq: runs W-bit ALU ops through a 4-bit ALU one nibble per clock, LSB first.
module nibble_serial_alu_seq #(
  parameter int NIBBLES = 4
) (
  input logic clk,
  input logic rst_n,
  nibble_serial_alu_seq_if.slave io
);
  localparam int W = 4 * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] idx;
  logic [IW+1:0] sh;
  logic [W-1:0] a_r, b_r, acc, acc_nxt;
  logic [2:0] op_r;
  logic c_r, run, last, accept;
  always_comb begin
    run = state == RUN;
    last = idx == IW'(NIBBLES - 1);
    accept = !run && io.start;
    state_nxt = run ? (last ? DONE : RUN) : (io.start ? RUN : IDLE);
    sh = {idx, 2'b00};
    // splice the ALU nibble into the accumulator at the current slice
    acc_nxt = (acc & ~(W'(4'hF) << sh)) | (W'(io.alu_out) << sh);
    io.busy = run;
    io.done = state == DONE;
    io.alu_a = run ? 4'(a_r >> sh) : '0;
    io.alu_b = run ? 4'(b_r >> sh) : '0;
    io.alu_signal = run ? op_r : '0;
    io.alu_cin = run ? c_r : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      a_r <= '0;
      b_r <= '0;
      op_r <= '0;
      c_r <= 1'b0;
      acc <= '0;
      io.result <= '0;
      io.carry <= 1'b0;
      io.zero <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_r <= io.a;
        b_r <= io.b;
        op_r <= io.op;
        c_r <= io.cin_init;
        idx <= '0;
      end else if (run) begin
        acc <= acc_nxt;
        c_r <= io.alu_cout;
        idx <= last ? '0 : idx + IW'(1);
        if (last) begin
          io.result <= acc_nxt;
          io.carry <= io.alu_cout;
          io.zero <= acc_nxt == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_alu_seq.sv
// tb_nibble_serial_alu_seq: directed checks of the nibble sequencer against a behavioural 4-bit ALU.
module tb_nibble_serial_alu_seq;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, STUB = 3'd7;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [3:0] cin_seq;
  logic [15:0] a_seq;
  logic [4:0] alu_sum;
  nibble_serial_alu_seq_if #(.NIBBLES(4)) io();
  nibble_serial_alu_seq #(.NIBBLES(4)) dut(.clk(clk), .rst_n(rst_n), .io(io.slave));
  always #5 clk = ~clk;
  // 4-bit ALU: 0 add, 1 subtract (a + ~b + cin), others a pass-through stub (a^b, cout=cin)
  always_comb begin
    alu_sum = io.alu_signal == ADD ? {1'b0, io.alu_a} + {1'b0, io.alu_b} + 5'(io.alu_cin) :
              io.alu_signal == SUB ? {1'b0, io.alu_a} + {1'b0, ~io.alu_b} + 5'(io.alu_cin) :
              {io.alu_cin, io.alu_a ^ io.alu_b};
    io.alu_out = alu_sum[3:0];
    io.alu_cout = alu_sum[4];
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [2:0] o, input logic ci,
                        input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] er, input logic ec, input logic ez);
    io.start = 1'b1;
    io.op = o;
    io.cin_init = ci;
    io.a = av;
    io.b = bv;
    step();
    io.start = 1'b0;
    io.a = 16'hDEAD;
    io.b = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      chk({tag, " busy"}, 32'(io.busy), 32'd1);
      chk({tag, " done_run"}, 32'(io.done), 32'd0);
      chk({tag, " signal"}, 32'(io.alu_signal), 32'(o));
      cin_seq[i] = io.alu_cin;
      a_seq[4*i+:4] = io.alu_a;
      step();
    end
    chk({tag, " done"}, 32'(io.done), 32'd1);
    chk({tag, " busy_done"}, 32'(io.busy), 32'd0);
    chk({tag, " result"}, 32'(io.result), 32'(er));
    chk({tag, " carry"}, 32'(io.carry), 32'(ec));
    chk({tag, " zero"}, 32'(io.zero), 32'(ez));
    chk({tag, " alu_a_idle"}, 32'(io.alu_a), 32'd0);
    step();
    chk({tag, " done_after"}, 32'(io.done), 32'd0);
  endtask
  initial begin
    int pulses;
    io.start = 1'b0;
    io.op = ADD;
    io.cin_init = 1'b0;
    io.a = '0;
    io.b = '0;
    step();
    step();
    chk("rst busy", 32'(io.busy), 32'd0);
    chk("rst done", 32'(io.done), 32'd0);
    chk("rst result", 32'(io.result), 32'd0);
    chk("rst carry", 32'(io.carry), 32'd0);
    chk("rst zero", 32'(io.zero), 32'd1);
    chk("rst alu_a", 32'(io.alu_a), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle busy", 32'(io.busy), 32'd0);
    run_op("add_chain", ADD, 1'b0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0);
    chk("add_chain cin_seq", 32'(cin_seq), 32'h000E);
    run_op("add_wrap", ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
    run_op("sub_eq", SUB, 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1);
    run_op("sub_5_3", SUB, 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0);
    run_op("stub", STUB, 1'b1, 16'hA5C3, 16'h0000, 16'hA5C3, 1'b1, 1'b0);
    chk("stub alu_a_seq", 32'(a_seq), 32'h0000A5C3);
    chk("stub cin_seq", 32'(cin_seq), 32'h000F);
    // start held high: only IDLE/DONE cycles accept, garbage operands during RUN are ignored
    io.start = 1'b1;
    io.op = ADD;
    io.cin_init = 1'b0;
    io.a = 16'h0001;
    io.b = 16'h0001;
    step();
    for (int i = 0; i < 4; i++) begin
      io.a = 16'h1111 * 16'(i + 3);
      io.b = 16'h0F0F;
      chk("hold busy1", 32'(io.busy), 32'd1);
      chk("hold done1_run", 32'(io.done), 32'd0);
      step();
    end
    chk("hold done1", 32'(io.done), 32'd1);
    chk("hold result1", 32'(io.result), 32'h0002);
    io.a = 16'h0100;
    io.b = 16'h0200;
    step();
    for (int i = 0; i < 4; i++) begin
      io.a = 16'h7777;
      chk("hold busy2", 32'(io.busy), 32'd1);
      chk("hold done2_run", 32'(io.done), 32'd0);
      chk("hold result_held", 32'(io.result), 32'h0002);
      step();
    end
    chk("hold done2", 32'(io.done), 32'd1);
    chk("hold result2", 32'(io.result), 32'h0300);
    io.start = 1'b0;
    step();
    chk("hold idle busy", 32'(io.busy), 32'd0);
    chk("hold idle done", 32'(io.done), 32'd0);
    // reset asserted at the edge closing RUN cycle 2
    io.start = 1'b1;
    io.a = 16'h0001;
    io.b = 16'h0001;
    step();
    io.start = 1'b0;
    step();
    step();
    chk("mid busy", 32'(io.busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid rst busy", 32'(io.busy), 32'd0);
    chk("mid rst done", 32'(io.done), 32'd0);
    chk("mid rst result", 32'(io.result), 32'd0);
    chk("mid rst zero", 32'(io.zero), 32'd1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      pulses += int'(io.done);
      step();
    end
    chk("mid no_done", 32'(pulses), 32'd0);
    chk("mid result_after", 32'(io.result), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
